// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that frames one requester character at a time onto a shared UART txd line.
module uart_tx_arb #(
    parameter int    CH     = 4,
    parameter int    DW     = 8,
    parameter int    SW     = 1,
    parameter string PARITY = "NONE",
    parameter int    BDW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BDW-1:0]        cfg_div,
    input  logic [CH-1:0]         req_vld,
    input  logic [CH*DW-1:0]      req_dat,
    output logic [CH-1:0]         req_rdy,
    output logic                  txd,
    output logic                  busy,
    output logic [$clog2(CH)-1:0] gnt_idx
);
    localparam int IW  = $clog2(CH);
    localparam int MX  = DW > SW ? DW : SW;
    localparam int CW  = $clog2(MX + 1);
    localparam bit PEN = PARITY != "NONE";
    localparam bit ODD = PARITY == "ODD";

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  ptr, sel, j;
    logic           found, hs, par;
    logic [DW-1:0]  sh, sel_dat;
    logic [BDW-1:0] div, cnt, cnt_nxt;
    logic [CW-1:0]  bitn, bitn_nxt;

    // First valid requester after the last grant, wrapping around.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_dat = '0;
        j       = '0;
        for (int k = 1; k <= CH; k++) begin
            j = IW'((int'(ptr) + k) % CH);
            if (!found && req_vld[j]) begin
                found   = 1'b1;
                sel     = j;
                sel_dat = DW'(req_dat >> (int'(j) * DW));
            end
        end
    end

    assign hs      = state == IDLE && found && rst_n;
    assign req_rdy = hs ? (CH'(1) << sel) : '0;
    assign busy    = state != IDLE;
    assign txd     = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : (state == PAR) ? par : 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bitn_nxt  = bitn;
        if (state != IDLE && cnt != '0)
            cnt_nxt = cnt - 1'b1;
        else
            case (state)
                IDLE: if (hs) begin
                    state_nxt = START;
                    cnt_nxt   = cfg_div;
                end
                START: begin
                    state_nxt = DATA;
                    cnt_nxt   = div;
                end
                DATA: begin
                    cnt_nxt  = div;
                    bitn_nxt = bitn + 1'b1;
                    if (bitn == CW'(DW - 1)) begin
                        state_nxt = PEN ? PAR : STOP;
                        bitn_nxt  = '0;
                    end
                end
                PAR: begin
                    state_nxt = STOP;
                    cnt_nxt   = div;
                end
                STOP: begin
                    cnt_nxt  = div;
                    bitn_nxt = bitn + 1'b1;
                    if (bitn == CW'(SW - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        bitn_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IW'(CH - 1);
            gnt_idx <= '0;
            cnt     <= '0;
            bitn    <= '0;
            div     <= '0;
            sh      <= '0;
            par     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bitn  <= bitn_nxt;
            if (hs) begin
                ptr     <= sel;
                gnt_idx <= sel;
                div     <= cfg_div;
                sh      <= sel_dat;
                par     <= ODD ? ~^sel_dat : ^sel_dat;
            end else if (state == DATA && cnt == '0) begin
                sh <= sh >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench; expected frames are queued as stimulus is set up and
// checked cycle by cycle by a UART receiver model on txd.
module tb_uart_tx_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_div = 16'd3;
    logic [3:0]  req_vld;
    logic [31:0] req_dat;
    logic [3:0]  req_rdy, req_rdy_e, req_rdy_o;
    logic        txd, busy, txd_e, busy_e, txd_o, busy_o;
    logic [1:0]  gnt_idx, gnt_e, gnt_o;

    uart_tx_arb dut (.clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .req_vld(req_vld), .req_dat(req_dat),
                     .req_rdy(req_rdy), .txd(txd), .busy(busy), .gnt_idx(gnt_idx));
    uart_tx_arb #(.PARITY("EVEN"), .SW(2)) dut_e (.clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .req_vld(req_vld),
                     .req_dat(req_dat), .req_rdy(req_rdy_e), .txd(txd_e), .busy(busy_e), .gnt_idx(gnt_e));
    uart_tx_arb #(.PARITY("ODD")) dut_o (.clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .req_vld(req_vld),
                     .req_dat(req_dat), .req_rdy(req_rdy_o), .txd(txd_o), .busy(busy_o), .gnt_idx(gnt_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int idx; int dat; int div; int gap;} exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_frame(input int i, input int d, input int dv, input int g);
        sb.push_back('{i, d, dv, g});
    endtask

    // Requester model: holds valid/data until accepted, then offers the next queued byte.
    int hs_n[4] = '{default: 0}, lim[4] = '{default: 0}, off[4] = '{default: 0};
    int rdy_cyc[4] = '{default: 0}, hs_cyc[4] = '{default: 0};
    logic [7:0] seq[4][4];
    logic [3:0] hs_v, rdy_v;

    initial begin
        req_vld = '0;
        req_dat = '0;
        forever begin
            @(posedge clk);
            hs_v  = req_vld & req_rdy;
            rdy_v = req_rdy;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rdy_v[i]) rdy_cyc[i]++;
                if (hs_v[i]) begin
                    hs_n[i]++;
                    hs_cyc[i] = cyc;
                end
                req_vld[i] = hs_n[i] < lim[i];
                if (req_vld[i]) req_dat[i*8 +: 8] = seq[i][hs_n[i] - off[i]];
            end
        end
    end

    task automatic load(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1);
        seq[i][0] = b0;
        seq[i][1] = b1;
        off[i] = hs_n[i];
        lim[i] = hs_n[i] + n;
    endtask

    // Receiver model on the main line: every cycle of the frame must sit at the expected level.
    initial begin
        exp_t e;
        logic prev = 1'b1;
        logic [7:0] rx;
        int start, last = 0, bad, d, b, c, lvl;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd) begin
                start = cyc;
                check("frame_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    d = e.div;
                    bad = 0;
                    rx = '0;
                    ab = 0;
                    check("gnt_idx", gnt_idx, e.idx);
                    check("start_at_hs", start, hs_cyc[e.idx]);
                    if (e.gap != 0) check("frame_gap", start - last, e.gap);
                    last = start;
                    for (int t = 0; t < 10 * (d + 1); t++) begin
                        if (t > 0) @(negedge clk);
                        if (!rst_n) begin
                            ab = 1;
                            break;
                        end
                        b = t / (d + 1);
                        c = t % (d + 1);
                        lvl = b == 0 ? 0 : b <= 8 ? (e.dat >> (b - 1)) & 1 : 1;
                        if (txd !== lvl[0] || busy !== 1'b1) bad++;
                        if (b >= 1 && b <= 8 && c == d / 2) rx[b-1] = txd;
                    end
                    if (!ab) begin
                        @(negedge clk);
                        check("busy_after_stop", busy, 0);
                        check("frame_shape", bad, 0);
                        check("rx_byte", rx, e.dat);
                    end
                end
            end
            prev = txd;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_hs(input int i, output int at);
        int h = hs_n[i], n = 0;
        while (hs_n[i] == h && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("hs_timeout", n < 500, 1);
        at = hs_cyc[i];
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 1000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic rst_on(input int div);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) lim[i] = hs_n[i];
        cfg_div = 16'(div);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, r;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_gnt_idx", gnt_idx, 0);
        check("rst_txd_e", txd_e, 1);

        // single character
        @(negedge clk);
        rst_n = 1'b1;
        r = rdy_cyc[0];
        load(0, 1, 8'h55, 8'h00);
        expect_frame(0, 8'h55, 3, 0);
        drain();
        check("single_rdy_pulses", rdy_cyc[0] - r, 1);

        // round robin from reset release
        rst_on(1);
        load(0, 2, 8'hA0, 8'hB0);
        load(1, 1, 8'hA1, 8'h00);
        load(2, 1, 8'hA2, 8'h00);
        load(3, 1, 8'hA3, 8'h00);
        repeat (2) @(negedge clk);
        expect_frame(0, 8'hA0, 1, 0);
        expect_frame(1, 8'hA1, 1, 21);
        expect_frame(2, 8'hA2, 1, 21);
        expect_frame(3, 8'hA3, 1, 21);
        expect_frame(0, 8'hB0, 1, 21);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // parity and two stop bits on the parity instances
        rst_on(2);
        @(negedge clk);
        rst_n = 1'b1;
        load(0, 1, 8'h07, 8'h00);
        expect_frame(0, 8'h07, 2, 0);
        wait_hs(0, n);
        goto(n + 27);
        check("even_parity", txd_e, 1);
        check("odd_parity", txd_o, 0);
        goto(n + 32);
        check("odd_stop_busy", busy_o, 1);
        goto(n + 33);
        check("odd_idle_busy", busy_o, 0);
        check("even_stop2_txd", txd_e, 1);
        goto(n + 35);
        check("even_stop2_busy", busy_e, 1);
        goto(n + 36);
        check("even_idle_busy", busy_e, 0);
        drain();

        // minimum divider stream
        rst_on(0);
        @(negedge clk);
        rst_n = 1'b1;
        r = rdy_cyc[2];
        seq[2][2] = 8'h5A;
        load(2, 3, 8'h3C, 8'hC3);
        expect_frame(2, 8'h3C, 0, 0);
        expect_frame(2, 8'hC3, 0, 11);
        expect_frame(2, 8'h5A, 0, 11);
        drain();
        check("min_div_rdy_pulses", rdy_cyc[2] - r, 3);

        // divider change during DATA
        rst_on(3);
        @(negedge clk);
        rst_n = 1'b1;
        load(1, 2, 8'h96, 8'h69);
        expect_frame(1, 8'h96, 3, 0);
        expect_frame(1, 8'h69, 7, 41);
        wait_hs(1, n);
        goto(n + 12);
        cfg_div = 16'd7;
        drain();

        // reset in the middle of requester 3's character
        rst_on(3);
        @(negedge clk);
        rst_n = 1'b1;
        load(3, 2, 8'hF0, 8'h33);
        expect_frame(3, 8'hF0, 3, 0);
        wait_hs(3, n);
        goto(n + 13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_req_rdy", req_rdy, 0);
        check("async_rst_gnt_idx", gnt_idx, 0);
        load(1, 1, 8'h11, 8'h00);
        repeat (2) @(negedge clk);
        expect_frame(1, 8'h11, 3, 0);
        expect_frame(3, 8'h33, 3, 41);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Synthesizable round-robin scheduler and serializer that shares one UART transmit line among `CH` byte-stream requesters. Each requester offers characters over a valid/ready handshake. The block grants one character at a time, frames it (start bit, LSB-first data, optional parity, stop bits) at a runtime-programmable bit period, and drives `txd`. It sits between on-chip debug/console sources and the pad, and its line format matches the team's UART bench model so that model can act as the receiver.

## Interface
- `CH`, 4: number of requesters, 2..16
- `DW`, 8: data bits per character, 5..8
- `SW`, 1: stop bits, ≥1
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD"
- `BDW`, 16: width of the bit-period divider

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `cfg_div`  in  BDW  clock cycles per bit minus 1
- `req_vld`  in  CH  per-requester character valid
- `req_dat`  in  CH*DW  per-requester character; requester i uses bits [i*DW +: DW]
- `req_rdy`  out  CH  per-requester accept, one-hot or zero
- `txd`  out  1  serial output, idle high
- `busy`  out  1  high while a character is on the line (START..STOP)
- `gnt_idx`  out  $clog2(CH)  index of the most recently accepted requester

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- **IDLE**
  - `txd`=1.
  - Selection searches for the first asserted `req_vld` in the order ptr+1, ptr+2, …, ptr+CH, all modulo CH.
  - `req_rdy` is asserted, combinationally, only for the selected requester.
  - A handshake occurs when `req_vld[i]&req_rdy[i]`.
  - On the handshake, the block latches the data, latches `cfg_div` into a private divider register, sets ptr←i and `gnt_idx`←i, and moves to START.
- **START**: `txd`=0 for one bit period.
- **DATA**: `txd`=bit k, k=0..DW-1, LSB first, one bit period each.
- **PAR**
  - Entered only if PARITY≠"NONE".
  - EVEN sends `^dat`; ODD sends `~^dat`.
- **STOP**: `txd`=1 for SW bit periods, then the FSM returns to IDLE.
- **Bit period**
  - A down-counter loads the latched divider at every bit start and advances the bit when it reaches 0.
  - Each bit therefore lasts exactly `cfg_div+1` cycles.
  - `cfg_div`=0 is legal and gives 1 cycle per bit.
- **Divider changes**: changes to `cfg_div` during a character do not affect that character; the new value takes effect at the next handshake.
- **Requester rules**
  - Requesters must hold `req_vld` and `req_dat` stable until accepted.
  - `req_rdy` is 0 in every state except IDLE.
- **Reset values**
  - `txd`=1, `busy`=0, `req_rdy`=0, `gnt_idx`=0.
  - ptr=CH-1, so requester 0 has top priority first.
  - FSM=IDLE, counters 0.
- **Reset during a character**
  - `txd` returns high immediately (asynchronous) and the character is dropped; no retransmission.
  - The requester was already released at its handshake.

## Timing
- The handshake happens at edge N. `txd` falls and `busy` rises after edge N.
- Frame length F = (1+DW+P+SW)·(cfg_div+1) cycles, with P=1 if parity is enabled, else 0.
- After the last stop bit the FSM spends exactly one IDLE cycle, during which the next handshake may occur. Back-to-back characters therefore start every F+1 cycles; the extra cycle extends the stop level.
- `busy` falls on the edge that enters IDLE.
- Each `req_rdy` pulse is exactly one cycle wide per accepted character.
- If no requester is valid, the FSM stays in IDLE and ptr is unchanged.
- A single active requester is granted repeatedly, with no penalty cycles beyond the IDLE cycle.

## Test plan
- **Single character**
  - Stimulus: defaults, `cfg_div`=3, requester 0 sends 0x55.
  - Required: `txd` low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4. `busy` high for exactly 40 cycles. `req_rdy[0]` pulses once. `gnt_idx`=0.
- **Round robin**
  - Stimulus: all four requesters hold valid from reset release with distinct data 0xA0..0xA3, `cfg_div`=1.
  - Required: grant order 0,1,2,3,0. Frame starts are 21 cycles apart. Bytes are received intact by the bench UART model at the matching baud.
- **Parity**
  - Stimulus: PARITY="EVEN", send 0x07.
  - Required: parity bit 1. Same test with "ODD" requires parity bit 0. SW=2 requires the stop level to last 2 bit periods before IDLE.
- **Minimum divider**
  - Stimulus: `cfg_div`=0, requester 2 streams 3 characters.
  - Required: each frame is 10 cycles, frame starts are 11 cycles apart, `req_rdy[2]` pulses every 11 cycles.
- **Divider change mid-frame**
  - Stimulus: `cfg_div` changed from 3 to 7 during DATA.
  - Required: the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- **Reset mid-frame**
  - Stimulus: assert `rst_n`=0 during DATA of requester 3's character.
  - Required: `txd`=1 and `busy`=0 without waiting for a clock edge. After release with requesters 1 and 3 valid, requester 1 is granted first.
